seven_segment_scanner: RTL and testbench



---
 rtl/seven_segment_pkg.sv | 17 +
 rtl/seven_segment_hex_decode.sv | 11 +
 rtl/seven_segment_scanner.sv | 125 ++++++++++++
 tb/tb_seven_segment_scanner.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/seven_segment_pkg.sv
// Shared types and constants for the multiplexed seven-segment display scanner.
package seven_segment_pkg;

  typedef enum logic {
    DEAD   = 1'b0,
    ACTIVE = 1'b1
  } scan_state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
  localparam logic [6:0] HEX_FONT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seven_segment_hex_decode.sv
// Combinational hex nibble to active-low segment pattern.
module seven_segment_hex_decode
  import seven_segment_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] segments_n_c
);

  assign segments_n_c = HEX_FONT[nibble];

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexed common-anode display driver with frame latching, dead time,
// PWM brightness and leading-zero blanking.
module seven_segment_scanner
  import seven_segment_pkg::*;
#(
  parameter int unsigned NUM_DIGITS          = 4,
  parameter int unsigned ACTIVE_CYCLES       = 256,
  parameter int unsigned DEAD_CYCLES         = 16,
  parameter int unsigned BLANK_LEADING_ZEROS = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [15:0]           value_in,
  input  logic [2:0]            brightness,
  input  logic                  display_en,
  output logic [6:0]            segments_n,
  output logic [NUM_DIGITS-1:0] digit_en_n,
  output logic                  frame_start
);

  localparam int unsigned MAX_CYC   = (ACTIVE_CYCLES > DEAD_CYCLES) ? ACTIVE_CYCLES : DEAD_CYCLES;
  localparam int unsigned CNT_W     = $clog2(MAX_CYC);
  localparam int unsigned DIG_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned PWM_SHIFT = $clog2(ACTIVE_CYCLES) - 3;

  scan_state_e           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DIG_W-1:0]      digit_q, digit_d;
  logic [15:0]           shadow_q;
  logic                  restart_q;
  logic                  load_c;
  logic                  frame_c;
  logic [3:0]            nibble_c;
  logic                  upper_nz_c;
  logic                  blank_c;
  logic                  duty_c;
  logic                  lit_c;
  logic [6:0]            font_c;
  logic [6:0]            segments_d;
  logic [NUM_DIGITS-1:0] digit_en_d;

  // State and output registers; restart_q forces a fresh frame on the first edge out of reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= DEAD;
      cnt_q       <= '0;
      digit_q     <= '0;
      shadow_q    <= 16'h0000;
      restart_q   <= 1'b1;
      segments_n  <= SEG_OFF;
      digit_en_n  <= '1;
      frame_start <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      digit_q     <= digit_d;
      restart_q   <= 1'b0;
      if (load_c) shadow_q <= value_in;
      segments_n  <= segments_d;
      digit_en_n  <= digit_en_d;
      frame_start <= frame_c;
    end
  end

  // Slot sequencing: DEAD_CYCLES dark, then ACTIVE_CYCLES of PWM, then next digit
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_W'(1);
    digit_d = digit_q;
    load_c  = 1'b0;
    frame_c = 1'b0;
    if (restart_q) begin
      state_d = DEAD;
      cnt_d   = '0;
      digit_d = '0;
      frame_c = 1'b1;
    end else begin
      case (state_q)
        DEAD: begin
          if (cnt_q == CNT_W'(DEAD_CYCLES - 1)) begin
            state_d = ACTIVE;
            cnt_d   = '0;
          end
        end
        ACTIVE: begin
          if (cnt_q == CNT_W'(ACTIVE_CYCLES - 1)) begin
            state_d = DEAD;
            cnt_d   = '0;
            if (digit_q == DIG_W'(NUM_DIGITS - 1)) begin
              digit_d = '0;
              load_c  = 1'b1;
              frame_c = 1'b1;
            end else begin
              digit_d = digit_q + DIG_W'(1);
            end
          end
        end
        default: begin
          state_d = DEAD;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Lit decision and next output values for the current digit
  always_comb begin
    nibble_c   = shadow_q[{digit_q, 2'b00} +: 4];
    upper_nz_c = 1'b0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (int'(digit_q) <= i && shadow_q[4*i +: 4] != 4'h0) upper_nz_c = 1'b1;
    end
    blank_c    = (BLANK_LEADING_ZEROS != 0) && (digit_q != '0) && !upper_nz_c;
    duty_c     = 3'(cnt_q >> PWM_SHIFT) <= brightness;
    lit_c      = (state_q == ACTIVE) && !restart_q && display_en && !blank_c && duty_c;
    segments_d = lit_c ? font_c : SEG_OFF;
    digit_en_d = lit_c ? ~(NUM_DIGITS'(1) << digit_q) : '1;
  end

  seven_segment_hex_decode u_decode (
    .nibble       (nibble_c),
    .segments_n_c (font_c)
  );

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Self-checking bench for seven_segment_scanner: vector table, corner sequences,
// and randomized traffic checked against a frame-position reference model.
module tb_seven_segment_scanner;

  localparam int ACT   = 16;
  localparam int DEADC = 2;
  localparam int SLOT  = ACT + DEADC;
  localparam int FRAME = 4 * SLOT;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] value_in;
  logic [2:0]  brightness;
  logic        display_en;
  logic [6:0]  segments_n;
  logic [3:0]  digit_en_n;
  logic        frame_start;

  int checks   = 0;
  int failures = 0;

  logic [6:0] font [16];

  typedef struct packed {
    logic [15:0]     value;
    logic [2:0]      bright;
    logic [3:0][6:0] seg;
    logic [3:0][4:0] lit;
  } vec_t;

  vec_t vecs [6];

  seven_segment_scanner #(
    .NUM_DIGITS(4), .ACTIVE_CYCLES(ACT), .DEAD_CYCLES(DEADC), .BLANK_LEADING_ZEROS(1)
  ) dut (
    .clk(clk), .rst(rst), .value_in(value_in), .brightness(brightness),
    .display_en(display_en), .segments_n(segments_n), .digit_en_n(digit_en_n),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Display of the cycle at frame position q (q = 0 is the frame_start cycle)
  function automatic void model_out(input bit dark, input int q, input logic [15:0] s,
                                    input logic [2:0] b, input bit en,
                                    output logic [6:0] seg, output logic [3:0] den);
    int d, p;
    logic [3:0] nib;
    bit lit;
    seg = 7'h7F;
    den = 4'hF;
    if (dark) return;
    d = q / SLOT;
    p = q % SLOT - DEADC;
    if (p < 0) return;
    nib = 4'(s >> (4 * d));
    lit = en && (p / (ACT / 8)) <= int'(b) && !(d > 0 && (s >> (4 * d)) == 16'h0);
    if (lit) begin
      seg = font[nib];
      den = 4'hF & ~(4'(1) << d);
    end
  endfunction

  // Reference model: pos = -1 is the restart cycle right after reset
  int          pos = -1;
  logic [15:0] mshadow = 16'h0;
  bit          pdark = 1'b1;
  int          ppos = 0;
  logic [15:0] pshadow = 16'h0;
  logic [2:0]  pbright = 3'd0;
  bit          pen = 1'b0;

  always @(negedge clk) begin
    logic [6:0] eseg;
    logic [3:0] eden;
    if (rst) begin
      chk("rst_seg", 16'(segments_n), 16'h7F);
      chk("rst_en", 16'(digit_en_n), 16'hF);
      chk("rst_fs", 16'(frame_start), 16'h0);
      pos = -1; mshadow = 16'h0; pdark = 1'b1;
    end else begin
      model_out(pdark, ppos, pshadow, pbright, pen, eseg, eden);
      chk("mon_seg", 16'(segments_n), 16'(eseg));
      chk("mon_en", 16'(digit_en_n), 16'(eden));
      chk("mon_fs", 16'(frame_start), 16'(pos == 0));
      chk("mon_onehot", 16'($countones(~digit_en_n) <= 1), 16'h1);
      pdark = (pos < 0); ppos = pos; pshadow = mshadow;
      pbright = brightness; pen = display_en;
      pos = (pos + 1) % FRAME;
      if (pos == 0 && ppos >= 0) mshadow = value_in;
    end
  end

  task automatic wait_fs();
    bit ok = 1'b0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (frame_start) begin ok = 1'b1; break; end
    end
    chk("fs_wait", 16'(ok), 16'h1);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int         lit [4];
    logic [6:0] seg [4];
    @(posedge clk); #1;
    value_in = v.value; brightness = v.bright; display_en = 1'b1;
    wait_fs();
    wait_fs();
    for (int d = 0; d < 4; d++) begin lit[d] = 0; seg[d] = 7'h7F; end
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++)
        if (!digit_en_n[d]) begin lit[d]++; seg[d] = segments_n; end
    end
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("vec%0d_seg%0d", idx, d), 16'(seg[d]), 16'(v.seg[d]));
      chk($sformatf("vec%0d_lit%0d", idx, d), 16'(lit[d]), 16'(v.lit[d]));
    end
  endtask

  initial begin
    int en_cnt, fs_cnt, fs_at;
    logic [15:0] fnt [16];
    fnt = '{16'h40, 16'h79, 16'h24, 16'h30, 16'h19, 16'h12, 16'h02, 16'h78,
            16'h00, 16'h10, 16'h08, 16'h03, 16'h46, 16'h21, 16'h06, 16'h0E};
    for (int i = 0; i < 16; i++) font[i] = 7'(fnt[i]);

    vecs[0] = '{16'h12AF, 3'd7, {7'h79, 7'h24, 7'h08, 7'h0E}, {5'd16, 5'd16, 5'd16, 5'd16}};
    vecs[1] = '{16'h0050, 3'd7, {7'h7F, 7'h7F, 7'h12, 7'h40}, {5'd0,  5'd0,  5'd16, 5'd16}};
    vecs[2] = '{16'h0000, 3'd7, {7'h7F, 7'h7F, 7'h7F, 7'h40}, {5'd0,  5'd0,  5'd0,  5'd16}};
    vecs[3] = '{16'h1111, 3'd0, {7'h79, 7'h79, 7'h79, 7'h79}, {5'd2,  5'd2,  5'd2,  5'd2}};
    vecs[4] = '{16'h8000, 3'd3, {7'h00, 7'h40, 7'h40, 7'h40}, {5'd8,  5'd8,  5'd8,  5'd8}};
    vecs[5] = '{16'hC0D0, 3'd5, {7'h46, 7'h40, 7'h21, 7'h40}, {5'd12, 5'd12, 5'd12, 5'd12}};

    rst = 1'b1; value_in = 16'h12AF; brightness = 3'd7; display_en = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_seg", 16'(segments_n), 16'h7F);
    chk("reset_en", 16'(digit_en_n), 16'hF);
    chk("reset_fs", 16'(frame_start), 16'h0);
    @(posedge clk); #1 rst = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Value change during digit 2's slot is held off until the next frame
    @(posedge clk); #1 value_in = 16'h1111; brightness = 3'd7;
    wait_fs(); wait_fs();
    repeat (40) @(negedge clk);
    @(posedge clk); #1 value_in = 16'h2222;
    repeat (20) @(negedge clk);
    chk("tear_d3_en", 16'(digit_en_n), 16'h7);
    chk("tear_d3_seg", 16'(segments_n), 16'h79);
    wait_fs();
    repeat (25) @(negedge clk);
    chk("tear_next_en", 16'(digit_en_n), 16'hD);
    chk("tear_next_seg", 16'(segments_n), 16'h24);

    // Asynchronous reset during digit 1's active phase
    wait_fs();
    repeat (25) @(negedge clk);
    @(posedge clk); #1;
    chk("prerst_seg", 16'(segments_n), 16'h24);
    #2 rst = 1'b1;
    #1;
    chk("async_seg", 16'(segments_n), 16'h7F);
    chk("async_en", 16'(digit_en_n), 16'hF);
    @(posedge clk); #1 rst = 1'b0;
    fs_at = 0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      if (frame_start && fs_at == 0) fs_at = i;
      if (fs_at != 0) break;
    end
    chk("rst_fs_latency", 16'(fs_at), 16'h2);
    repeat (2) begin
      @(negedge clk);
      chk("rst_dead_en", 16'(digit_en_n), 16'hF);
    end
    @(negedge clk);
    chk("rst_d0_en", 16'(digit_en_n), 16'hE);
    chk("rst_d0_seg", 16'(segments_n), 16'h40);

    // display_en low for a full frame: dark but still framing
    @(posedge clk); #1 display_en = 1'b0;
    @(negedge clk);
    en_cnt = 0; fs_cnt = 0;
    for (int c = 0; c < FRAME; c++) begin
      @(negedge clk);
      if (digit_en_n != 4'hF) en_cnt++;
      if (frame_start) fs_cnt++;
    end
    chk("disp_off_lit", 16'(en_cnt), 16'h0);
    chk("disp_off_fs", 16'(fs_cnt), 16'h1);
    @(posedge clk); #1 display_en = 1'b1;

    // Randomized traffic, checked cycle by cycle by the model
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk); #1;
      if ($urandom_range(19, 0) == 0) value_in = 16'($urandom);
      if ($urandom_range(29, 0) == 0) brightness = 3'($urandom);
      if ($urandom_range(49, 0) == 0) display_en = ($urandom_range(3, 0) != 0);
      if ($urandom_range(15, 0) == 0) value_in = value_in & 16'h00FF;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
